// File: rtl/snn_inference_ctrl.sv
// Inference sequencer for the spiking network: accepts a sample, clears and runs the
// datapath for NUM_STEPS timesteps, then scans the readout accumulators for the argmax.
module snn_inference_ctrl #(
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH_P     = 8,
    parameter int NUM_STEPS   = 16,
    parameter int STEP_W      = 8,
    parameter int IDX_W       = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH_P-1:0] in_data_i,
    output logic [WIDTH_P-1:0] data_o,
    output logic               clear_o,
    output logic               step_en_o,
    output logic [IDX_W-1:0]   acc_sel_o,
    input  logic [WIDTH_P-1:0] acc_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [IDX_W-1:0]   out_class_o,
    output logic [WIDTH_P-1:0] out_score_o,
    output logic               busy_o
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH_P-1:0] data_q, data_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [IDX_W-1:0]   acc_sel_q, acc_sel_d;
    logic [WIDTH_P-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [IDX_W-1:0]   out_class_q, out_class_d;
    logic [WIDTH_P-1:0] out_score_q, out_score_d;
    logic               clear_q, clear_d;
    logic               step_en_q, step_en_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic [WIDTH_P-1:0] cand_score;
    logic [IDX_W-1:0]   cand_idx;

    // Strict compare keeps the lower index on ties.
    always_comb begin
        cand_score = best_score_q;
        cand_idx   = best_idx_q;
        if (acc_data_i > best_score_q) begin
            cand_score = acc_data_i;
            cand_idx   = acc_sel_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        step_d       = step_q;
        acc_sel_d    = acc_sel_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        out_class_d  = out_class_q;
        out_score_d  = out_score_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    data_d  = in_data_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                step_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                    acc_sel_d    = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    state_d      = SCAN;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            SCAN: begin
                best_score_d = cand_score;
                best_idx_d   = cand_idx;
                if (acc_sel_q == IDX_W'(NUM_CLASSES - 1)) begin
                    out_class_d = cand_idx;
                    out_score_d = cand_score;
                    state_d     = DONE;
                end else begin
                    acc_sel_d = acc_sel_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Control outputs are decoded from the next state so they are registered.
        clear_d     = (state_d == CLEAR);
        step_en_d   = (state_d == RUN);
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            data_q       <= '0;
            step_q       <= '0;
            acc_sel_q    <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            out_class_q  <= '0;
            out_score_q  <= '0;
            clear_q      <= 1'b0;
            step_en_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            step_q       <= step_d;
            acc_sel_q    <= acc_sel_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            out_class_q  <= out_class_d;
            out_score_q  <= out_score_d;
            clear_q      <= clear_d;
            step_en_q    <= step_en_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign data_o      = data_q;
    assign clear_o     = clear_q;
    assign step_en_o   = step_en_q;
    assign acc_sel_o   = acc_sel_q;
    assign out_valid_o = out_valid_q;
    assign out_class_o = out_class_q;
    assign out_score_o = out_score_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Scoreboard bench for snn_inference_ctrl: mock accumulator bank, cycle-accurate
// timing monitor on the falling edge, expected argmax results queued at accept.
module tb_snn_inference_ctrl;
    localparam int NC = 10;
    localparam int W  = 8;
    localparam int NS = 16;
    localparam int SW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  data_o;
    logic          clear;
    logic          step_en;
    logic [IW-1:0] acc_sel;
    logic [W-1:0]  acc_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_class;
    logic [W-1:0]  out_score;
    logic          busy;

    logic [W-1:0]  acc_mem [16];

    always #5 clk = ~clk;
    assign acc_data = acc_mem[acc_sel];

    snn_inference_ctrl #(.NUM_CLASSES(NC), .WIDTH_P(W), .NUM_STEPS(NS), .STEP_W(SW), .IDX_W(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .data_o(data_o), .clear_o(clear), .step_en_o(step_en),
        .acc_sel_o(acc_sel), .acc_data_i(acc_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_class_o(out_class), .out_score_o(out_score), .busy_o(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [IW-1:0] cls;
        logic [W-1:0]  score;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t model_argmax();
        exp_t e;
        e.cls   = '0;
        e.score = '0;
        for (int i = 0; i < NC; i++) begin
            if (acc_mem[i] > e.score) begin
                e.score = acc_mem[i];
                e.cls   = IW'(i);
            end
        end
        return e;
    endfunction

    int            cyc = 0;
    int            acc_edge = 0;
    int            acc_cnt = 0;
    bit            in_flight = 0;
    bit            b2b = 0;
    bit            b2b_seen = 0;
    logic [W-1:0]  exp_data = '0;
    logic [IW-1:0] last_cls = '0;
    logic [W-1:0]  last_score = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle n = 1 is the cycle right after the accepting edge.
    always @(negedge clk) begin
        int n;
        exp_t e;
        if (!rst_n) begin
            in_flight = 0;
            sb.delete();
            exp_data = '0;
            chk("rst_clear", clear, 0);
            chk("rst_step_en", step_en, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_data", data_o, 0);
        end else begin
            n = cyc - acc_edge + 1;
            chk("data_o", data_o, exp_data);
            chk("busy", busy, in_flight);
            chk("in_ready", in_ready, !in_flight);
            chk("clear", clear, in_flight && n == 1);
            chk("step_en", step_en, in_flight && n >= 2 && n <= NS + 1);
            chk("out_valid", out_valid, in_flight && n >= NS + NC + 2);
            if (in_flight && n >= NS + 2 && n <= NS + NC + 1)
                chk("acc_sel", acc_sel, n - NS - 2);
            if (out_valid && sb.size() > 0) begin
                chk("out_class", out_class, sb[0].cls);
                chk("out_score", out_score, sb[0].score);
            end
            if (out_valid && out_ready) begin
                if (sb.size() > 0) begin
                    last_cls   = out_class;
                    last_score = out_score;
                    void'(sb.pop_front());
                end
                in_flight = 0;
            end
            if (!b2b) b2b_seen = 0;
            if (in_valid && in_ready) begin
                e = model_argmax();
                sb.push_back(e);
                exp_data = in_data;
                if (b2b) begin
                    if (b2b_seen) chk("b2b_gap", cyc + 1 - acc_edge, 29);
                    b2b_seen = 1;
                end
                acc_edge  = cyc + 1;
                in_flight = 1;
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                           input logic [W-1:0] a3, input logic [W-1:0] a9);
        for (int i = 0; i < 16; i++) acc_mem[i] = '0;
        acc_mem[0] = a0; acc_mem[1] = a1; acc_mem[2] = a2; acc_mem[3] = a3; acc_mem[9] = a9;
    endtask

    task automatic send(input logic [W-1:0] d);
        bit ok;
        bit done = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            ok = in_ready;
            tick();
            if (ok) done = 1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (!busy && sb.size() == 0) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int target;
        bit seen;
        set_acc(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i % 10 == 0) begin
                chk("idle_acc_sel", acc_sel, 0);
                chk("idle_out_class", out_class, 0);
                chk("idle_out_score", out_score, 0);
            end
        end

        // Single inference with a tie at the maximum
        set_acc(5, 9, 30, 30, 0);
        acc_mem[4] = 8'd2;
        out_ready = 1'b1;
        send(8'd200);
        wait_idle();
        chk("t1_class", last_cls, 2);
        chk("t1_score", last_score, 30);
        chk("t1_data", data_o, 200);

        // Backpressure with an ignored sample while busy
        set_acc(1, 50, 3, 0, 0);
        out_ready = 1'b0;
        send(8'd77);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        if (!seen) chk("t2_valid_timeout", 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin in_data = 8'd99; in_valid = 1'b1; end
            if (i == 6) in_valid = 1'b0;
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        chk("t2_class", last_cls, 1);
        chk("t2_score", last_score, 50);
        chk("t2_data", data_o, 77);

        // All-zero accumulators
        set_acc(0, 0, 0, 0, 0);
        send(8'd1);
        wait_idle();
        chk("t3_class", last_cls, 0);
        chk("t3_score", last_score, 0);

        // Maximum only in the last class
        set_acc(0, 0, 0, 0, 8'd255);
        send(8'd2);
        wait_idle();
        chk("t4_class", last_cls, 9);
        chk("t4_score", last_score, 255);

        // Asynchronous reset in the middle of RUN
        set_acc(10, 20, 15, 0, 0);
        send(8'd55);
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_step_en", step_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_clear", clear, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_acc(4, 3, 8, 8, 7);
        send(8'd66);
        wait_idle();
        chk("t5_class", last_cls, 2);
        chk("t5_score", last_score, 8);

        // Back-to-back accepts with in_valid held high
        set_acc(0, 12, 0, 40, 40);
        out_ready = 1'b1;
        b2b = 1;
        target = acc_cnt + 3;
        in_valid = 1'b1;
        in_data = 8'($urandom_range(0, 255));
        for (int i = 0; i < 200 && acc_cnt < target; i++) begin
            tick();
            in_data = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
        if (acc_cnt < target) chk("b2b_timeout", acc_cnt, target);
        wait_idle();
        b2b = 0;
        chk("t6_class", last_cls, 3);
        chk("t6_score", last_score, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
